// File: rtl/jam_param_search.sv
// Exhaustive job-assignment search: walks every permutation of N jobs over
// N workers in lexicographic order, sums the cost of each assignment read
// from an external combinational ROM, and keeps the best total together
// with the number of permutations that reach it.
module jam_param_search #(
    parameter int N   = 8,
    parameter int IW  = 3,
    parameter int CW  = 7,
    parameter int SW  = 10,
    parameter int MCW = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           Start,
    input  logic           Mode,
    output logic [IW-1:0]  W,
    output logic [IW-1:0]  J,
    input  logic [CW-1:0]  Cost,
    output logic [MCW-1:0] MatchCount,
    output logic [SW-1:0]  BestCost,
    output logic           Valid,
    output logic           Busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUM  = 2'd1;
    localparam logic [1:0] S_NEXT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [IW-1:0]  perm_q [N];
    logic [IW-1:0]  perm_d [N];
    logic [IW-1:0]  i_q, i_d;
    logic [SW-1:0]  acc_q, acc_d;
    logic [SW-1:0]  best_q, best_d;
    logic [MCW-1:0] match_q, match_d;
    logic           first_q, first_d;
    logic           mode_q, mode_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;

    logic           pivotFound;
    logic [IW-1:0]  pivotIdx;
    logic [IW-1:0]  succIdx;
    logic [IW-1:0]  pivotVal;
    logic [IW-1:0]  succVal;
    logic [IW-1:0]  swapped  [N];
    logic [IW-1:0]  permNext [N];
    logic [IW-1:0]  jobSel;
    logic           better;

    // Lexicographic successor of the current permutation. Every index is a
    // loop constant so the whole step unrolls into plain muxes.
    always_comb begin
        pivotFound = 1'b0;
        pivotIdx   = '0;
        for (int k = 0; k < N - 1; k++) begin
            if (perm_q[k] < perm_q[k+1]) begin
                pivotFound = 1'b1;
                pivotIdx   = IW'(k);
            end
        end
        // The suffix after the pivot is descending, so the right-most larger
        // element is the smallest one larger than the pivot.
        succIdx = '0;
        for (int m = 1; m < N; m++) begin
            for (int p = 0; p < m; p++) begin
                if (pivotIdx == IW'(p) && perm_q[m] > perm_q[p]) begin
                    succIdx = IW'(m);
                end
            end
        end
        pivotVal = '0;
        succVal  = '0;
        for (int k = 0; k < N; k++) begin
            if (pivotIdx == IW'(k)) pivotVal = perm_q[k];
            if (succIdx == IW'(k))  succVal  = perm_q[k];
        end
        for (int k = 0; k < N; k++) begin
            if (pivotIdx == IW'(k))     swapped[k] = succVal;
            else if (succIdx == IW'(k)) swapped[k] = pivotVal;
            else                        swapped[k] = perm_q[k];
        end
        permNext = swapped;
        for (int p = 0; p < N - 1; p++) begin
            if (pivotIdx == IW'(p)) begin
                for (int k = p + 1; k < N; k++) begin
                    permNext[k] = swapped[N + p - k];
                end
            end
        end
    end

    // Job currently assigned to worker i, used as the ROM column address.
    always_comb begin
        jobSel = '0;
        for (int k = 0; k < N; k++) begin
            if (i_q == IW'(k)) jobSel = perm_q[k];
        end
    end

    // Controller: accepts Start, sums one permutation, then compares and steps.
    always_comb begin
        state_d = state_q;
        perm_d  = perm_q;
        i_d     = i_q;
        acc_d   = acc_q;
        best_d  = best_q;
        match_d = match_q;
        first_d = first_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        better  = mode_q ? (acc_q > best_q) : (acc_q < best_q);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    for (int k = 0; k < N; k++) perm_d[k] = IW'(k);
                    i_d     = '0;
                    acc_d   = '0;
                    first_d = 1'b1;
                    mode_d  = Mode;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                acc_d = acc_q + SW'(Cost);
                if (i_q == IW'(N - 1)) state_d = S_NEXT;
                else                   i_d     = i_q + 1'b1;
            end
            S_NEXT: begin
                if (first_q || better) begin
                    best_d  = acc_q;
                    match_d = MCW'(1);
                end else if (acc_q == best_q && match_q != '1) begin
                    match_d = match_q + 1'b1;
                end
                first_d = 1'b0;
                if (!pivotFound) begin
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    perm_d  = permNext;
                    i_d     = '0;
                    acc_d   = '0;
                    state_d = S_SUM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset that discards any partial run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            for (int k = 0; k < N; k++) perm_q[k] <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            best_q  <= '0;
            match_q <= '0;
            first_q <= 1'b0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            perm_q  <= perm_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            best_q  <= best_d;
            match_q <= match_d;
            first_q <= first_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign W          = (state_q == S_SUM) ? i_q : '0;
    assign J          = (state_q == S_SUM) ? jobSel : '0;
    assign MatchCount = match_q;
    assign BestCost   = best_q;
    assign Valid      = valid_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_jam_param_search.sv
// Bench for jam_param_search: three small instances (N=5, N=5 with a 4-bit
// saturating counter, N=3) driven one at a time, expected results queued
// at Start and compared when Valid rises.
module tb_jam_param_search;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        startA, startB, startC;
    logic        modeA, modeB, modeC;
    logic [2:0]  wA, jA, wB, jB;
    logic [1:0]  wC, jC;
    logic [6:0]  costA, costB, costC;
    logic [15:0] mcA, mcC;
    logic [3:0]  mcB;
    logic [9:0]  bestA, bestB, bestC;
    logic        validA, validB, validC;
    logic        busyA, busyB, busyC;
    logic        diagA;

    // Cost ROMs: A is all-zero or diagonal (0 on w==j, else 10), B all-zero, C is 3w+j.
    assign costA = diagA ? ((wA == jA) ? 7'd0 : 7'd10) : 7'd0;
    assign costB = 7'd0;
    assign costC = 7'(wC) * 7'd3 + 7'(jC);

    jam_param_search #(.N(5), .IW(3), .CW(7), .SW(10), .MCW(16)) dutA (
        .CLK(CLK), .RST(RST), .Start(startA), .Mode(modeA), .W(wA), .J(jA),
        .Cost(costA), .MatchCount(mcA), .BestCost(bestA), .Valid(validA), .Busy(busyA));

    jam_param_search #(.N(5), .IW(3), .CW(7), .SW(10), .MCW(4)) dutB (
        .CLK(CLK), .RST(RST), .Start(startB), .Mode(modeB), .W(wB), .J(jB),
        .Cost(costB), .MatchCount(mcB), .BestCost(bestB), .Valid(validB), .Busy(busyB));

    jam_param_search #(.N(3), .IW(2), .CW(7), .SW(10), .MCW(16)) dutC (
        .CLK(CLK), .RST(RST), .Start(startC), .Mode(modeC), .W(wC), .J(jC),
        .Cost(costC), .MatchCount(mcC), .BestCost(bestC), .Valid(validC), .Busy(busyC));

    int          sel;
    logic        selValid, selBusy;
    logic [9:0]  selBest;
    logic [15:0] selMatch;
    logic [2:0]  selW, selJ;
    int          selN;

    // Route the instance under test onto one set of observation signals.
    always_comb begin
        selValid = validA; selBusy = busyA; selBest = bestA; selMatch = mcA;
        selW = wA; selJ = jA; selN = 5;
        case (sel)
            1: begin
                selValid = validB; selBusy = busyB; selBest = bestB;
                selMatch = {12'b0, mcB}; selW = wB; selJ = jB; selN = 5;
            end
            2: begin
                selValid = validC; selBusy = busyC; selBest = bestC; selMatch = mcC;
                selW = {1'b0, wC}; selJ = {1'b0, jC}; selN = 3;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] best;
        logic [31:0] match;
        int          lat;
    } exp_t;

    exp_t sbQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic setStart(input int which, input logic val, input logic m);
        case (which)
            0:       begin startA = val; modeA = m; end
            1:       begin startB = val; modeB = m; end
            default: begin startC = val; modeC = m; end
        endcase
    endtask

    // One full run: queue the expectation, pulse Start, wait (bounded) for Valid, compare.
    task automatic applyStimulus(input int which, input logic mode, input int expBest,
                                 input int expMatch, input int expLat, input bit busyPulse);
        exp_t e;
        exp_t got;
        int   cycles;
        bit   rangeOk;
        sel = which;
        e.best = expBest; e.match = expMatch; e.lat = expLat;
        sbQ.push_back(e);
        @(negedge CLK);
        setStart(which, 1'b1, mode);
        @(negedge CLK);
        setStart(which, 1'b0, ~mode);
        cycles  = 1;
        rangeOk = 1'b1;
        checkOutput("acceptBusy", 32'(selBusy), 32'd1);
        checkOutput("acceptValid", 32'(selValid), 32'd0);
        while (!selValid && cycles < 5000) begin
            @(negedge CLK);
            cycles++;
            setStart(which, busyPulse && cycles == 30, ~mode);
            if (int'(selW) >= selN || int'(selJ) >= selN) rangeOk = 1'b0;
        end
        setStart(which, 1'b0, ~mode);
        if (!selValid) begin
            checkOutput("validTimeout", 32'(selValid), 32'd1);
        end else begin
            got = sbQ.pop_front();
            checkOutput("bestCost", 32'(selBest), got.best);
            checkOutput("matchCount", 32'(selMatch), got.match);
            checkOutput("latency", 32'(cycles), 32'(got.lat));
            checkOutput("busyDone", 32'(selBusy), 32'd0);
            checkOutput("addrRange", 32'(rangeOk), 32'd1);
            repeat (3) @(negedge CLK);
            checkOutput("validHeld", 32'(selValid), 32'd1);
            checkOutput("bestHeld", 32'(selBest), got.best);
        end
    endtask

    initial begin
        RST = 1'b1;
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        modeA = 1'b0; modeB = 1'b0; modeC = 1'b0;
        diagA = 1'b0;
        sel = 0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput("rstValid", 32'(selValid), 32'd0);
            checkOutput("rstBusy", 32'(selBusy), 32'd0);
            checkOutput("rstBest", 32'(selBest), 32'd0);
            checkOutput("rstMatch", 32'(selMatch), 32'd0);
            checkOutput("rstW", 32'(selW), 32'd0);
            checkOutput("rstJ", 32'(selJ), 32'd0);
        end

        // All-zero costs: every one of 5! permutations ties.
        applyStimulus(0, 1'b0, 0, 120, 721, 1'b0);
        // Same with a 4-bit counter: saturates at 15.
        applyStimulus(1, 1'b0, 0, 15, 721, 1'b0);
        // N=3, cost 3w+j: every assignment sums to 12.
        applyStimulus(2, 1'b0, 12, 6, 25, 1'b0);
        // Restart from DONE in max mode.
        applyStimulus(2, 1'b1, 12, 6, 25, 1'b0);
        // Diagonal costs, minimise; a stray Start mid-run must be ignored.
        diagA = 1'b1;
        applyStimulus(0, 1'b0, 0, 1, 721, 1'b1);
        // Diagonal costs, maximise: derangements of 5 give 50, counted 44 times.
        applyStimulus(0, 1'b1, 50, 44, 721, 1'b0);

        // Abort a run with reset, then rerun.
        sel = 0;
        @(negedge CLK);
        setStart(0, 1'b1, 1'b0);
        @(negedge CLK);
        setStart(0, 1'b0, 1'b1);
        repeat (50) @(negedge CLK);
        checkOutput("midRunBusy", 32'(selBusy), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("abortValid", 32'(selValid), 32'd0);
        checkOutput("abortBusy", 32'(selBusy), 32'd0);
        checkOutput("abortBest", 32'(selBest), 32'd0);
        checkOutput("abortMatch", 32'(selMatch), 32'd0);
        checkOutput("abortW", 32'(selW), 32'd0);
        checkOutput("abortJ", 32'(selJ), 32'd0);
        applyStimulus(0, 1'b0, 0, 1, 721, 1'b0);

        checkOutput("queueEmpty", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
